// File: rtl/mdu_pkg.sv
// Shared core package: major opcodes, M-extension funct3 encodings, MDU FSM
// states and operand-signedness decode.
package mdu_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    // Only MULHU, DIVU and REMU treat rs1 as unsigned.
    function automatic logic op_a_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : ~f3[1];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One BPC-bit slice of the iterative datapath: shift-add multiply or
// restoring divide on a {hi, lo} register pair.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            is_div,
    input  logic [XLEN:0]   hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN:0]   hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;

    // Multiply: lo holds the multiplier and fills with product LSBs from the top.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        hi      = hi_i;
        lo      = lo_i;
        sum     = '0;
        shifted = '0;
        for (int i = 0; i < BPC; i++) begin
            if (is_div) begin
                shifted = {hi[XLEN-1:0], lo[XLEN-1]};
                lo      = {lo[XLEN-2:0], 1'b0};
                if (shifted >= {1'b0, m_i}) begin
                    hi    = shifted - {1'b0, m_i};
                    lo[0] = 1'b1;
                end else begin
                    hi = shifted;
                end
            end else begin
                sum = {1'b0, hi[XLEN-1:0]} + (lo[0] ? {1'b0, m_i} : '0);
                hi  = {1'b0, sum[XLEN:1]};
                lo  = {sum[0], lo[XLEN-1:1]};
            end
        end
        hi_o = hi;
        lo_o = lo;
    end

endmodule

// File: rtl/mdu.sv
// Iterative RV M-extension multiply/divide unit: FSM, operand registers,
// fast paths for divide-by-zero and signed overflow, and result sign fix-up.
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] r,
    output logic [4:0]      rd_addr_out,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam int STEPS = XLEN / BPC;
    localparam int CNT_W = (STEPS > 2) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic            neg_q, neg_d;
    logic [4:0]      tag_q, tag_d;
    logic [XLEN-1:0] r_q, r_d;
    logic            ready_en_q, ready_en_d;

    logic [XLEN:0]   hi_n;
    logic [XLEN-1:0] lo_n;

    logic            accept, is_div, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] div_res, calc_res;

    mdu_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
        .is_div (op_q[2]),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .m_i    (m_q),
        .hi_o   (hi_n),
        .lo_o   (lo_n)
    );

    // Handshake: a request transfers on a rising edge where in_valid & in_ready
    // and flush is low; a result transfers where out_valid & out_ready. Once
    // out_valid rises, r and rd_addr_out stay put until that transfer or a flush.
    always_comb begin
        accept   = in_valid & in_ready & ~flush;
        is_div   = funct3[2];
        a_neg    = op_a_signed(funct3) & a[XLEN-1];
        b_neg    = op_b_signed(funct3) & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = is_div & (b == '0);
        div_ovf  = is_div & ~funct3[0] & (a == MOST_NEG) & (b == '1);
    end

    always_comb begin
        prod     = {hi_n[XLEN-1:0], lo_n};
        prod_fix = neg_q ? -prod : prod;
        div_res  = op_q[1] ? hi_n[XLEN-1:0] : lo_n;
        if (op_q[2]) begin
            calc_res = neg_q ? -div_res : div_res;
        end else if (op_q == F3_MUL) begin
            calc_res = prod_fix[XLEN-1:0];
        end else begin
            calc_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        m_d        = m_q;
        neg_d      = neg_q;
        tag_d      = tag_q;
        r_d        = r_q;
        ready_en_d = 1'b1;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    op_d  = funct3;
                    tag_d = rd_addr_in;
                    neg_d = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    hi_d  = '0;
                    lo_d  = is_div ? a_mag : b_mag;
                    m_d   = is_div ? b_mag : a_mag;
                    if (div_zero) begin
                        r_d     = funct3[1] ? a : '1;
                        state_d = STATE_DONE;
                    end else if (div_ovf) begin
                        r_d     = funct3[1] ? '0 : a;
                        state_d = STATE_DONE;
                    end else begin
                        cnt_d   = CNT_MAX;
                        state_d = STATE_CALC;
                    end
                end
            end
            STATE_CALC: begin
                hi_d = hi_n;
                lo_d = lo_n;
                if (cnt_q == '0) begin
                    r_d     = calc_res;
                    state_d = STATE_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STATE_DONE: begin
                if (out_ready) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
        // Flush wins over everything, including a same-cycle out_ready.
        if (flush) begin
            state_d = STATE_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STATE_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            m_q        <= '0;
            neg_q      <= 1'b0;
            tag_q      <= '0;
            r_q        <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            m_q        <= m_d;
            neg_q      <= neg_d;
            tag_q      <= tag_d;
            r_q        <= r_d;
            ready_en_q <= ready_en_d;
        end
    end

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = (state_q == STATE_IDLE) & ready_en_q;
    assign out_valid   = (state_q == STATE_DONE);
    assign busy        = (state_q != STATE_IDLE);
    assign r           = r_q;
    assign rd_addr_out = tag_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: one BPC=1 and one BPC=4 instance
// sharing operand, flush, out_ready and reset inputs.
module tb_mdu;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_valid_4 = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_addr_in = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, busy;
    logic [31:0] r;
    logic [4:0]  rd_addr_out;
    logic [1:0]  dbg_state;
    logic        in_ready_4, out_valid_4, busy_4;
    logic [31:0] r_4;
    logic [4:0]  rd_addr_out_4;
    logic [1:0]  dbg_state_4;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    mdu #(.XLEN(32), .BPC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .a(a), .b(b), .rd_addr_in(rd_addr_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .r(r),
        .rd_addr_out(rd_addr_out), .busy(busy), .dbg_state(dbg_state)
    );

    mdu #(.XLEN(32), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .funct3(funct3), .a(a), .b(b), .rd_addr_in(rd_addr_in), .flush(flush),
        .out_valid(out_valid_4), .out_ready(out_ready), .r(r_4),
        .rd_addr_out(rd_addr_out_4), .busy(busy_4), .dbg_state(dbg_state_4)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for its result, check latency/result/tag, optionally
    // hold out_ready low for some cycles, then retire it.
    task automatic run_op(input bit use4, input logic [2:0] f3, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] tag,
                          input logic [31:0] exp_r, input int exp_lat, input int hold,
                          input string name);
        int guard;
        int lat;
        logic [31:0] exp_v;
        guard = 0;
        @(negedge clk);
        while (!(use4 ? in_ready_4 : in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({name, "_rdy"}, 64'(guard < 100), 64'd1);
        exp_q.push_back(exp_r);
        funct3 = f3;
        a = av;
        b = bv;
        rd_addr_in = tag;
        out_ready = 1'b0;
        if (use4) in_valid_4 = 1'b1;
        else in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid_4 = 1'b0;
        lat = 1;
        while (!(use4 ? out_valid_4 : out_valid) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp_v = exp_q.pop_front();
        check_eq({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({name, "_r"}, 64'(use4 ? r_4 : r), 64'(exp_v));
        check_eq({name, "_tag"}, 64'(use4 ? rd_addr_out_4 : rd_addr_out), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({name, "_hold_r"}, 64'(use4 ? r_4 : r), 64'(exp_v));
            check_eq({name, "_hold_valid"}, 64'(use4 ? out_valid_4 : out_valid), 64'd1);
            check_eq({name, "_hold_inrdy"}, 64'(use4 ? in_ready_4 : in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        check_eq({name, "_inrdy_at_retire"}, 64'(use4 ? in_ready_4 : in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({name, "_valid_after"}, 64'(use4 ? out_valid_4 : out_valid), 64'd0);
        check_eq({name, "_inrdy_after"}, 64'(use4 ? in_ready_4 : in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_r", 64'(r), 64'd0);
        check_eq("rst_tag", 64'(rd_addr_out), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rel_in_ready_pre", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rel_in_ready_post", 64'(in_ready), 64'd1);

        run_op(0, F_MUL,    32'd7,        32'hFFFFFFFD, 5'h11, 32'hFFFFFFEB, 33, 0, "mul_7_m3");
        run_op(0, F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, 33, 0, "mulhu_ff");
        run_op(0, F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'h00000000, 33, 0, "mulh_ff");
        run_op(0, F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'hFFFFFFFF, 33, 0, "mulhsu_ff");
        run_op(0, F_MUL,    32'h12345678, 32'h00000010, 5'h05, 32'h23456780, 33, 0, "mul_shift");
        run_op(0, F_MULHU,  32'h12345678, 32'h00000010, 5'h06, 32'h00000001, 33, 0, "mulhu_shift");
        run_op(0, F_DIV,    32'hFFFFFFF9, 32'd2,        5'h07, 32'hFFFFFFFD, 33, 0, "div_m7_2");
        run_op(0, F_REM,    32'hFFFFFFF9, 32'd2,        5'h08, 32'hFFFFFFFF, 33, 0, "rem_m7_2");
        run_op(0, F_DIV,    32'd7,        32'hFFFFFFFE, 5'h09, 32'hFFFFFFFD, 33, 0, "div_7_m2");
        run_op(0, F_REM,    32'd7,        32'hFFFFFFFE, 5'h0A, 32'h00000001, 33, 0, "rem_7_m2");
        run_op(0, F_DIVU,   32'd100,      32'd7,        5'h0B, 32'd14,       33, 5, "divu_hold");
        run_op(0, F_REMU,   32'd100,      32'd7,        5'h0C, 32'd2,        33, 0, "remu_100_7");
        run_op(0, F_DIVU,   32'd100,      32'd0,        5'h0D, 32'hFFFFFFFF, 1,  0, "divu_by0");
        run_op(0, F_REMU,   32'd100,      32'd0,        5'h0E, 32'd100,      1,  0, "remu_by0");
        run_op(0, F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'h0F, 32'h80000000, 1,  0, "div_ovf");
        run_op(0, F_REM,    32'h80000000, 32'hFFFFFFFF, 5'h10, 32'h00000000, 1,  0, "rem_ovf");

        // request presented together with flush must not be taken
        @(negedge clk);
        funct3 = F_MUL;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check_eq("flush_accept_busy", 64'(busy), 64'd0);

        // flush a DIV in its tenth cycle
        @(negedge clk);
        funct3 = F_DIV;
        a = 32'hFFFFFFF9;
        b = 32'd2;
        rd_addr_in = 5'h12;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("flush_calc_state", 64'(dbg_state), 64'd1);
        check_eq("flush_calc_busy", 64'(busy), 64'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_state", 64'(dbg_state), 64'd0);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("flush_no_valid", 64'(seen), 64'd0);
        run_op(0, F_MUL, 32'd7, 32'hFFFFFFFD, 5'h13, 32'hFFFFFFEB, 33, 0, "mul_after_flush");

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        funct3 = F_MUL;
        a = 32'd5;
        b = 32'd9;
        rd_addr_in = 5'h14;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_r", 64'(r), 64'd0);
        check_eq("mid_rst_tag", 64'(rd_addr_out), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("mid_rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rel_in_ready_pre", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rel_in_ready_post", 64'(in_ready), 64'd1);
        run_op(0, F_MUL, 32'd7, 32'hFFFFFFFD, 5'h15, 32'hFFFFFFEB, 33, 0, "mul_after_rst");

        run_op(1, F_MUL, 32'd7,        32'hFFFFFFFD, 5'h16, 32'hFFFFFFEB, 9, 0, "bpc4_mul");
        run_op(1, F_DIV, 32'hFFFFFFF9, 32'd2,        5'h17, 32'hFFFFFFFD, 9, 0, "bpc4_div");
        run_op(1, F_REMU, 32'd100,     32'd7,        5'h18, 32'd2,        9, 0, "bpc4_remu");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
